// File: rtl/basic_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word shown combinationally on data_out.
// Write-to-visible latency one edge; enq dropped when full unless a pop frees the slot that same edge.
module basic_sync_fifo #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int AWIDTH = 4
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [WIDTH-1:0] data_in,
   input  logic             enq,
   input  logic             deq,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             full
);

   localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);
   localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic [AWIDTH:0]   count;
   logic              enq_ok;
   logic              deq_ok;

   assign valid_out = (count != '0);
   assign full      = (count == FULL_CNT);
   assign deq_ok    = deq && valid_out;
   // When full, a same-edge pop vacates rd_ptr == wr_ptr, so the write can land there.
   assign enq_ok    = enq && (!full || deq_ok);
   // Gate the head word so uninitialised storage never leaks out while empty.
   assign data_out  = valid_out ? mem[rd_ptr] : '0;

   always_ff @(posedge ACLK) begin
      if (enq_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (deq_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({enq_ok, deq_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_basic_sync_fifo.sv
// Randomised and directed checks of basic_sync_fifo against a queue-based reference model.
module tb_basic_sync_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;

   logic             ACLK;
   logic             ARESETn;
   logic [WIDTH-1:0] data_in;
   logic             enq;
   logic             deq;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             full;

   int checks;
   int errors;
   logic [WIDTH-1:0] ref_q[$];

   basic_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AWIDTH(4)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .data_in   (data_in),
      .enq       (enq),
      .deq       (deq),
      .data_out  (data_out),
      .valid_out (valid_out),
      .full      (full)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag);
      logic [WIDTH-1:0] exp_dat;
      exp_dat = (ref_q.size() != 0) ? ref_q[0] : '0;
      chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, ref_q.size() != 0});
      chk({tag, ".full"},  {31'd0, full},      {31'd0, ref_q.size() == DEPTH});
      chk({tag, ".data"},  data_out, exp_dat);
   endtask

   // Called at a negedge: drive inputs, advance one edge, update model, check at next negedge.
   task automatic cycle(input logic e, input logic d, input logic [WIDTH-1:0] din, input string tag);
      bit pop_ok;
      bit push_ok;
      enq = e;
      deq = d;
      data_in = din;
      pop_ok  = d && (ref_q.size() != 0);
      push_ok = e && ((ref_q.size() < DEPTH) || pop_ok);
      @(posedge ACLK);
      if (pop_ok)  void'(ref_q.pop_front());
      if (push_ok) ref_q.push_back(din);
      @(negedge ACLK);
      enq = 1'b0;
      deq = 1'b0;
      chk_outputs(tag);
   endtask

   initial begin
      int pushed;
      int guard;
      checks  = 0;
      errors  = 0;
      ARESETn = 1'b1;
      enq     = 1'b0;
      deq     = 1'b0;
      data_in = '0;

      // Reset then idle
      repeat (2) @(negedge ACLK);
      chk_outputs("in_reset");
      ARESETn = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, "idle");

      // Single word FWFT
      cycle(1'b1, 1'b0, 32'hA5A5_0001, "fwft_enq");
      chk("fwft_word", data_out, 32'hA5A5_0001);
      cycle(1'b0, 1'b1, '0, "fwft_deq");
      chk("fwft_empty", data_out, 32'h0);

      // Fill and overflow, then drain
      for (int i = 1; i <= 17; i++) cycle(1'b1, 1'b0, WIDTH'(i), "fill");
      chk("fill_full", {31'd0, full}, 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_order", data_out, WIDTH'(i));
         cycle(1'b0, 1'b1, '0, "drain");
      end
      chk("drain_empty", {31'd0, valid_out}, 32'd0);

      // Underflow
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "underflow");
      cycle(1'b1, 1'b0, 32'h55, "uf_enq");
      chk("uf_word", data_out, 32'h55);
      cycle(1'b0, 1'b1, '0, "uf_deq");
      chk("uf_single", {31'd0, valid_out}, 32'd0);

      // Simultaneous enq/deq while full
      for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, WIDTH'(i), "refill");
      cycle(1'b1, 1'b1, 32'h99, "full_both");
      chk("full_both_full", {31'd0, full}, 32'd1);
      chk("full_both_head", data_out, 32'd2);
      while (ref_q.size() != 0) cycle(1'b0, 1'b1, '0, "full_both_drain");

      // Simultaneous enq/deq while empty: no bypass
      cycle(1'b1, 1'b1, 32'h7, "empty_both");
      chk("empty_both_word", data_out, 32'h7);
      cycle(1'b0, 1'b1, '0, "empty_both_pop");

      // Random stream of 40 words, exercising pointer wrap
      pushed = 0;
      guard  = 0;
      while (pushed < 40 && guard < 1000) begin
         logic e;
         logic d;
         e = ($urandom_range(0, 9) < 6);
         d = ($urandom_range(0, 9) < 5);
         if (e && (ref_q.size() < DEPTH || (d && ref_q.size() != 0))) pushed++;
         cycle(e, d, $urandom, "rand");
         guard++;
      end
      chk("rand_budget", {31'd0, pushed >= 40}, 32'd1);

      // Top up, then reset asynchronously between edges
      while (ref_q.size() < DEPTH) cycle(1'b1, 1'b0, $urandom, "topup");
      @(posedge ACLK);
      #3;
      ARESETn = 1'b1;
      ref_q.delete();
      #1;
      chk_outputs("async_rst");
      @(negedge ACLK);
      chk_outputs("async_rst_hold");
      ARESETn = 1'b0;

      // Traffic restarts cleanly
      cycle(1'b1, 1'b0, 32'hCAFE_0001, "restart");
      chk("restart_word", data_out, 32'hCAFE_0001);
      for (int i = 0; i < 60; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, "rand2");
      while (ref_q.size() != 0) cycle(1'b0, 1'b1, '0, "final_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
